// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface div_if;
    logic        signed_div_i;
    logic [15:0] opdata1_i;
    logic [15:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div.sv
// 16-bit signed/unsigned restoring divider, one quotient bit per clock.
// Latency 17 edges from start (2 on divide-by-zero); requester stalls via stallreq_o until ready_o.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {FREE, DIV_BYZERO, DIV_ON, DIV_END} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [16:0] shifted;
    logic [16:0] diff;
    logic [15:0] step_rem;
    logic [15:0] step_quo;
    logic [15:0] mag1;
    logic [15:0] mag2;
    logic [15:0] quo_fix;
    logic [15:0] rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
        shifted  = {rem_q, quo_q[15]};
        diff     = shifted - {1'b0, dvs_q};
        step_rem = diff[16] ? shifted[15:0] : diff[15:0];
        step_quo = {quo_q[14:0], ~diff[16]};
        quo_fix  = neg_quo_q ? 16'(16'd0 - step_quo) : step_quo;
        rem_fix  = neg_rem_q ? 16'(16'd0 - step_rem) : step_rem;

        mag1 = (bus.signed_div_i && bus.opdata1_i[15]) ? 16'(16'd0 - bus.opdata1_i) : bus.opdata1_i;
        mag2 = (bus.signed_div_i && bus.opdata2_i[15]) ? 16'(16'd0 - bus.opdata2_i) : bus.opdata2_i;

        case (state_q)
            FREE: begin
                result_d = 32'd0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == 16'd0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = 5'd0;
                        rem_d     = 16'd0;
                        quo_d     = mag1;
                        dvs_d     = mag2;
                        neg_quo_d = bus.signed_div_i && (bus.opdata1_i[15] ^ bus.opdata2_i[15]);
                        neg_rem_d = bus.signed_div_i && bus.opdata1_i[15];
                    end
                end
            end
            DIV_BYZERO: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    result_d = 32'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = DIV_END;
                    result_d = 32'd0;
                    ready_d  = 1'b1;
                end
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    result_d = 32'd0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d  = DIV_END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            DIV_END: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    result_d = 32'd0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = FREE;
                result_d = 32'd0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= 5'd0;
            rem_q     <= 16'd0;
            quo_q     <= 16'd0;
            dvs_q     <= 16'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 32'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i && !ready_q && !bus.annul_i;
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected results queued at issue, checked when ready_o rises.
module tb_div;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] exp_q[$];

    div_if ifc ();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic sgn, input logic [15:0] a, input logic [15:0] b);
        int q;
        int r;
        if (b == 16'd0) return 32'd0;
        if (sgn) begin
            q = int'($signed(a)) / int'($signed(b));
            r = int'($signed(a)) % int'($signed(b));
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        return {r[15:0], q[15:0]};
    endfunction

    task automatic drive(input logic sgn, input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back(model(sgn, a, b));
        ifc.signed_div_i = sgn;
        ifc.opdata1_i    = a;
        ifc.opdata2_i    = b;
        ifc.start_i      = 1'b1;
    endtask

    // Called at a negedge with start_i already high; counts rising edges until ready_o.
    task automatic wait_ready(input string tag, input int exp_lat);
        int          edges;
        bit          stall_ok;
        logic [31:0] exp;
        edges    = 0;
        stall_ok = 1;
        if (ifc.stallreq_o !== 1'b1) stall_ok = 0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        while (edges < 40) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                ifc.opdata1_i = 16'($urandom);
                ifc.opdata2_i = 16'($urandom);
            end
            if (ifc.ready_o === 1'b1) break;
            if (ifc.stallreq_o !== 1'b1) stall_ok = 0;
        end
        if (ifc.ready_o !== 1'b1) begin
            chk({tag, "_timeout"}, 32'(edges), 32'(exp_lat));
            return;
        end
        chk({tag, "_lat"}, 32'(edges), 32'(exp_lat));
        chk({tag, "_res"}, ifc.result_o, exp);
        chk({tag, "_stall_during"}, 32'(stall_ok), 32'd1);
        chk({tag, "_stall_after"}, 32'(ifc.stallreq_o), 32'd0);
        @(negedge clk);
        chk({tag, "_hold"}, {ifc.result_o[30:0], ifc.ready_o}, {exp[30:0], 1'b1});
        ifc.start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_clear"}, {ifc.result_o[30:0], ifc.ready_o}, 32'd0);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [15:0] a, input logic [15:0] b);
        drive(sgn, a, b);
        #1;
        wait_ready(tag, (b == 16'd0) ? 2 : 17);
    endtask

    initial begin
        int  seen;
        bit  sgn;
        logic [15:0] ra;
        logic [15:0] rb;
        total = 0;
        bad   = 0;
        rst              = 1'b0;
        ifc.signed_div_i = 1'b0;
        ifc.opdata1_i    = 16'd0;
        ifc.opdata2_i    = 16'd0;
        ifc.start_i      = 1'b0;
        ifc.annul_i      = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ifc.ready_o), 32'd0);
        chk("rst_result", ifc.result_o, 32'd0);
        chk("rst_stall_idle", 32'(ifc.stallreq_o), 32'd0);
        ifc.start_i = 1'b1;
        #1;
        chk("rst_stall_req", 32'(ifc.stallreq_o), 32'd1);
        @(negedge clk);
        chk("rst_hold_ready", 32'(ifc.ready_o), 32'd0);
        ifc.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        run_div("u100_7",     1'b0, 16'h0064, 16'h0007);
        chk("u100_7_model", model(1'b0, 16'h0064, 16'h0007), 32'h0002000E);
        run_div("s_m100_7",   1'b1, 16'hFF9C, 16'h0007);
        run_div("u_div0",     1'b0, 16'h1234, 16'h0000);
        run_div("s_div0",     1'b1, 16'h8000, 16'h0000);
        run_div("u_ffff_1",   1'b0, 16'hFFFF, 16'h0001);
        run_div("s_ovf",      1'b1, 16'h8000, 16'hFFFF);
        run_div("u_8000_ffff",1'b0, 16'h8000, 16'hFFFF);
        run_div("s_7_m3",     1'b1, 16'h0007, 16'hFFFD);

        // annul mid-division
        ifc.signed_div_i = 1'b0;
        ifc.opdata1_i    = 16'h0064;
        ifc.opdata2_i    = 16'h0007;
        ifc.start_i      = 1'b1;
        repeat (8) @(negedge clk);
        ifc.annul_i = 1'b1;
        #1;
        chk("annul_stall", 32'(ifc.stallreq_o), 32'd0);
        @(negedge clk);
        chk("annul_ready", 32'(ifc.ready_o), 32'd0);
        ifc.annul_i = 1'b0;
        ifc.start_i = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.ready_o !== 1'b0) seen++;
        end
        chk("annul_no_ready", 32'(seen), 32'd0);
        run_div("after_annul", 1'b0, 16'h0064, 16'h0007);

        // reset mid-division with start held
        drive(1'b0, 16'd1000, 16'd3);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out", {ifc.result_o[30:0], ifc.ready_o}, 32'd0);
        chk("midrst_stall", 32'(ifc.stallreq_o), 32'd1);
        void'(exp_q.pop_front());
        ifc.opdata1_i = 16'd1000;
        ifc.opdata2_i = 16'd3;
        exp_q.push_back(model(1'b0, 16'd1000, 16'd3));
        rst = 1'b1;
        #1;
        wait_ready("after_rst", 17);

        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            run_div($sformatf("rnd%0d", i), sgn, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
